// File: rtl/string_hw_arbiter.sv
// -----------------------------------------------------------------------------
// string_hw_arbiter
//   Shares a single String_HW engine (0 compare, 1 to-upper, 2 to-lower,
//   3 reverse) between NUM_REQ requesters. A round-robin arbiter picks one
//   pending request in IDLE, latches its op code and operands onto the engine
//   bus, runs the go/done level handshake with a per-phase watchdog, and then
//   presents the registered result on the granted requester's response channel.
//
// Ports
//   clk, reset               clock; asynchronous active-low reset
//   req_valid/req_ready      per-requester request handshake (ready is a
//                            combinational one-hot accept strobe in IDLE)
//   req_index/req_a/req_b    per-requester op code and operands (packed lanes)
//   rsp_valid/rsp_ready      per-requester response handshake (valid one-hot)
//   rsp_result/rsp_error     shared registered response payload
//   eng_go/eng_index/eng_a/eng_b/eng_done/eng_result  String_HW engine bus
//   busy                     high in every state other than IDLE
// -----------------------------------------------------------------------------
module string_hw_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MAX_BLOCKS = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*4-1:0]           req_index,
  input  logic [NUM_REQ*32*MAX_BLOCKS-1:0] req_a,
  input  logic [NUM_REQ*32*MAX_BLOCKS-1:0] req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [32*MAX_BLOCKS-1:0]       rsp_result,
  output logic                           rsp_error,
  output logic                           eng_go,
  output logic [3:0]                     eng_index,
  output logic [32*MAX_BLOCKS-1:0]       eng_a,
  output logic [32*MAX_BLOCKS-1:0]       eng_b,
  input  logic                           eng_done,
  input  logic [32*MAX_BLOCKS-1:0]       eng_result,
  output logic                           busy
);

  localparam int unsigned SW = 32 * MAX_BLOCKS;
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  MAX_OP = 4'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GO      = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               eng_go_q, eng_go_d;
  logic [3:0]         eng_index_q, eng_index_d;
  logic [SW-1:0]      eng_a_q, eng_a_d;
  logic [SW-1:0]      eng_b_q, eng_b_d;
  logic [SW-1:0]      rsp_result_q, rsp_result_d;
  logic               rsp_error_q, rsp_error_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  // Per-requester views of the packed request lanes
  logic [3:0]    idx_arr [NUM_REQ];
  logic [SW-1:0] a_arr   [NUM_REQ];
  logic [SW-1:0] b_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign idx_arr[gi] = req_index[4*gi +: 4];
    assign a_arr[gi]   = req_a[SW*gi +: SW];
    assign b_arr[gi]   = req_b[SW*gi +: SW];
  end

  // Round-robin search starting just after the last served requester
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept strobe: only in IDLE and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found && reset) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    eng_go_d     = eng_go_q;
    eng_index_d  = eng_index_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = win_idx;
          eng_index_d = idx_arr[win_idx];
          eng_a_d     = a_arr[win_idx];
          eng_b_d     = b_arr[win_idx];
          timer_d     = '0;
          if (idx_arr[win_idx] <= MAX_OP) begin
            state_d  = GO;
            eng_go_d = 1'b1;
          end else begin
            // Unsupported op: answer with an error without touching the engine
            state_d      = RESP;
            rsp_error_d  = 1'b1;
            rsp_result_d = '0;
          end
        end
      end

      GO: begin
        if (eng_done) begin
          rsp_result_d = eng_result;
          rsp_error_d  = 1'b0;
          eng_go_d     = 1'b0;
          timer_d      = '0;
          state_d      = RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
          eng_go_d     = 1'b0;
          timer_d      = '0;
          state_d      = RELEASE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      RELEASE: begin
        // Wait for the engine to drop done so the next job starts clean
        if (!eng_done) begin
          timer_d = '0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
          timer_d      = '0;
          state_d      = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          timer_d      = '0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        eng_go_d = 1'b0;
      end
    endcase
  end

  // Registered status outputs derived from the upcoming state
  always_comb begin
    busy_d      = (state_d != IDLE);
    rsp_valid_d = '0;
    if (state_d == RESP) begin
      rsp_valid_d[grant_d] = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      timer_q      <= '0;
      eng_go_q     <= 1'b0;
      eng_index_q  <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      eng_go_q     <= eng_go_d;
      eng_index_q  <= eng_index_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign eng_go     = eng_go_q;
  assign eng_index  = eng_index_q;
  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_string_hw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_string_hw_arbiter
//   Directed and randomized requests from three requesters against a
//   behavioural String_HW engine stub. Operand byte 0 selects stub behaviour:
//   8'hFF never raises done, 8'hFE holds done high past the watchdog.
// -----------------------------------------------------------------------------
module tb_string_hw_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned MB   = 2;
  localparam int unsigned TO   = 64;
  localparam int unsigned SW   = 32 * MB;
  localparam int unsigned NB   = SW / 8;
  localparam int unsigned IW   = $clog2(NR);
  localparam int unsigned JOBS = 14;

  typedef struct {
    logic [3:0]    idx;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    int            gap;
  } job_t;

  typedef struct {
    logic [SW-1:0] res;
    logic          err;
    int            go_cycles;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NR-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*4-1:0]    req_index;
  logic [NR*SW-1:0]   req_a, req_b;
  logic [SW-1:0]      rsp_result, eng_a, eng_b, eng_result;
  logic               rsp_error, eng_go, eng_done, busy;
  logic [3:0]         eng_index;

  job_t job_q [NR][$];
  exp_t exp_q [NR][$];
  int   checks = 0;
  int   errors = 0;
  int   consumed = 0;

  string_hw_arbiter #(.NUM_REQ(NR), .MAX_BLOCKS(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .eng_go(eng_go), .eng_index(eng_index), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // String operation reference, byte k of the operand at bits [8k+7:8k]
  function automatic logic [SW-1:0] ref_op(input logic [3:0] idx, input logic [SW-1:0] a,
                                           input logic [SW-1:0] b);
    logic [SW-1:0] r;
    logic [7:0]    c;
    r = '0;
    case (idx)
      4'd0: r = (a == b) ? SW'(1) : '0;
      4'd1, 4'd2: begin
        for (int k = 0; k < NB; k++) begin
          c = 8'(a >> (8 * k));
          if (idx == 4'd1 && c >= "a" && c <= "z") c = c - 8'd32;
          if (idx == 4'd2 && c >= "A" && c <= "Z") c = c + 8'd32;
          r = r | (SW'(c) << (8 * k));
        end
      end
      4'd3: begin
        for (int k = 0; k < NB; k++) r = (r << 8) | SW'(8'(a >> (8 * k)));
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exp_t mk_exp(input job_t j);
    exp_t e;
    logic hang, stuck;
    hang  = (j.a[7:0] == 8'hFF);
    stuck = (j.a[7:0] == 8'hFE);
    e.err = (j.idx > 4'd3) || hang || stuck;
    e.res = e.err ? '0 : ref_op(j.idx, j.a, j.b);
    e.go_cycles = (j.idx > 4'd3) ? 0 : (hang ? TO : -1);
    return e;
  endfunction

  function automatic job_t mk_job(input logic [3:0] idx, input logic [SW-1:0] a,
                                  input logic [SW-1:0] b, input int gap);
    job_t j;
    j.idx = idx; j.a = a; j.b = b; j.gap = gap;
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    int   m;
    j.a = '0;
    for (int k = 0; k < NB; k++) j.a = (j.a << 8) | SW'(8'($urandom_range(65, 122)));
    j.b = ($urandom_range(0, 1) == 1) ? j.a : j.a ^ (SW'(1) << $urandom_range(0, SW - 1));
    m = $urandom_range(0, 99);
    j.idx = (m < 12) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    m = $urandom_range(0, 99);
    if (m < 8) j.a[7:0] = 8'hFF;
    else if (m < 16) j.a[7:0] = 8'hFE;
    j.gap = $urandom_range(0, 3);
    return j;
  endfunction

  // Requester driver: presents queued jobs, drops valid after the accept strobe
  initial begin
    logic [NR-1:0] rdy_seen;
    int            waited [NR];
    int            stall  [NR];
    job_t          j;
    req_valid = '0; req_index = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin waited[i] = 0; stall[i] = 0; end
    forever begin
      @(negedge clk);
      rdy_seen = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[IW'(i)] && rdy_seen[IW'(i)]) req_valid[IW'(i)] = 1'b0;
        if (reset && !req_valid[IW'(i)] && job_q[IW'(i)].size() > 0) begin
          if (waited[i] >= job_q[IW'(i)][0].gap) begin
            j = job_q[IW'(i)].pop_front();
            waited[i] = 0;
            req_index = (req_index & ~((NR*4)'(4'hF) << (4 * i))) | ((NR*4)'(j.idx) << (4 * i));
            req_a = (req_a & ~((NR*SW)'({SW{1'b1}}) << (SW * i))) | ((NR*SW)'(j.a) << (SW * i));
            req_b = (req_b & ~((NR*SW)'({SW{1'b1}}) << (SW * i))) | ((NR*SW)'(j.b) << (SW * i));
            req_valid[IW'(i)] = 1'b1;
            exp_q[IW'(i)].push_back(mk_exp(j));
          end else begin
            waited[i]++;
          end
        end
        // Response back-pressure with occasional long stalls
        if (stall[i] > 0) begin
          rsp_ready[IW'(i)] = 1'b0;
          stall[i]--;
        end else if ($urandom_range(0, 7) == 0) begin
          stall[i] = $urandom_range(3, 12);
          rsp_ready[IW'(i)] = 1'b0;
        end else begin
          rsp_ready[IW'(i)] = 1'b1;
        end
      end
    end
  end

  // Engine stub
  initial begin
    int   st, lat, cnt, hold;
    logic stuck;
    st = 0; lat = 0; cnt = 0; hold = 0; stuck = 1'b0;
    eng_done = 1'b0; eng_result = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        st = 0;
        eng_done = 1'b0;
      end else begin
        if (st == 0 && eng_go) begin
          if (eng_a[7:0] == 8'hFF) st = 3;
          else begin
            stuck = (eng_a[7:0] == 8'hFE);
            lat   = $urandom_range(0, 4);
            st    = 1;
          end
        end
        if (st == 1) begin
          if (lat == 0) begin
            eng_done   = 1'b1;
            eng_result = ref_op(eng_index, eng_a, eng_b);
            cnt  = 0;
            hold = stuck ? TO + 1 : $urandom_range(1, 3);
            st   = 2;
          end else lat--;
        end else if (st == 2) begin
          if (!eng_go) begin
            cnt++;
            if (cnt >= hold) begin eng_done = 1'b0; st = 0; end
          end
        end else if (st == 3) begin
          if (!eng_go) st = 0;
        end
      end
    end
  end

  // Monitor: round-robin grant model, operand hold, response scoreboard
  initial begin
    logic          in_job, found, seen_rsp;
    int            g, model_last, since, go_cnt, p;
    logic [NR-1:0] exp_rdy;
    logic [3:0]    c_idx;
    logic [SW-1:0] c_a, c_b, h_res;
    logic          h_err;
    exp_t          e;
    in_job = 1'b0; model_last = NR - 1; g = 0; since = 0; go_cnt = 0; seen_rsp = 1'b0;
    c_idx = '0; c_a = '0; c_b = '0; h_res = '0; h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_job = 1'b0;
        model_last = NR - 1;
        for (int i = 0; i < NR; i++) exp_q[IW'(i)].delete();
      end else begin
        check("busy", SW'(busy), SW'(in_job));
        exp_rdy = '0;
        found = 1'b0;
        p = 0;
        if (!in_job) begin
          for (int k = 1; k <= NR; k++) begin
            p = (model_last + k) % NR;
            if (!found && req_valid[IW'(p)]) begin
              found = 1'b1;
              exp_rdy[IW'(p)] = 1'b1;
              g = p;
            end
          end
        end
        check("req_ready", SW'(req_ready), SW'(exp_rdy));
        if (in_job) begin
          since++;
          check("eng_index hold", SW'(eng_index), SW'(c_idx));
          check("eng_a hold", eng_a, c_a);
          check("eng_b hold", eng_b, c_b);
          if (eng_go) go_cnt++;
          if (since == 1 && c_idx <= 4'd3) check("go latency", SW'(eng_go), SW'(1));
          if (rsp_valid != '0) begin
            check("rsp_valid onehot", SW'(rsp_valid), SW'(NR'(1) << g));
            if (seen_rsp) begin
              check("rsp_result stable", rsp_result, h_res);
              check("rsp_error stable", SW'(rsp_error), SW'(h_err));
            end else begin
              seen_rsp = 1'b1;
              h_res = rsp_result;
              h_err = rsp_error;
            end
            if (rsp_ready[IW'(g)]) begin
              if (exp_q[IW'(g)].size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: response for req %0d with nothing expected", g);
              end else begin
                e = exp_q[IW'(g)].pop_front();
                check("rsp_result", rsp_result, e.res);
                check("rsp_error", SW'(rsp_error), SW'(e.err));
                if (e.go_cycles >= 0) check("go cycles", SW'(go_cnt), SW'(e.go_cycles));
              end
              model_last = g;
              in_job = 1'b0;
              consumed++;
            end
          end
        end else begin
          check("rsp_valid idle", SW'(rsp_valid), '0);
          check("eng_go idle", SW'(eng_go), '0);
          if (found && req_ready == exp_rdy) begin
            in_job = 1'b1;
            since = 0; go_cnt = 0; seen_rsp = 1'b0;
            c_idx = 4'(req_index >> (4 * g));
            c_a   = SW'(req_a >> (SW * g));
            c_b   = SW'(req_b >> (SW * g));
          end
        end
      end
    end
  end

  // Main sequence
  initial begin
    int            total;
    logic [SW-1:0] hello;
    repeat (3) @(negedge clk);
    check("reset eng_go", SW'(eng_go), '0);
    check("reset busy", SW'(busy), '0);
    check("reset rsp_valid", SW'(rsp_valid), '0);
    check("reset rsp_error", SW'(rsp_error), '0);
    check("reset rsp_result", rsp_result, '0);
    check("reset eng_index", SW'(eng_index), '0);
    check("reset eng_a", eng_a, '0);
    check("reset req_ready", SW'(req_ready), '0);
    #2 reset = 1'b1;

    hello = SW'("Hello!");
    job_q[0].push_back(mk_job(4'd0, SW'("abcdefgh"), SW'("abcdefgh"), 0));
    for (int r = 0; r < 2; r++) begin
      job_q[0].push_back(mk_job(4'd1, SW'("ab"), SW'("Ab"), 0));
      job_q[1].push_back(mk_job(4'd1, SW'("ab"), SW'("Ab"), 0));
    end
    job_q[1].push_back(mk_job(4'd5, SW'("xyz"), SW'("xyz"), 0));
    job_q[2].push_back(mk_job(4'd2, {SW'("ABCDEFG"), 8'hFF}, '0, 0));
    job_q[0].push_back(mk_job(4'd3, hello, '0, 0));
    job_q[2].push_back(mk_job(4'd1, {SW'("qrstuvw"), 8'hFE}, '0, 1));
    total = 9;
    for (int i = 0; i < NR; i++) begin
      for (int n = 0; n < JOBS; n++) begin
        job_q[IW'(i)].push_back(rand_job());
        total++;
      end
    end
    for (int t = 0; t < 40000 && consumed < total; t++) @(negedge clk);
    check("responses consumed", SW'(consumed), SW'(total));

    // Reset in the middle of an engine handshake abandons the job
    job_q[0].push_back(mk_job(4'd1, {SW'("abcdefg"), 8'hFF}, '0, 0));
    for (int t = 0; t < 200 && !eng_go; t++) @(negedge clk);
    check("go before reset", SW'(eng_go), SW'(1));
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort eng_go", SW'(eng_go), '0);
    check("abort busy", SW'(busy), '0);
    check("abort rsp_valid", SW'(rsp_valid), '0);
    job_q[1].push_back(mk_job(4'd3, SW'("req1"), '0, 0));
    job_q[0].push_back(mk_job(4'd1, SW'("req0"), '0, 0));
    total = consumed + 2;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    for (int t = 0; t < 2000 && consumed < total; t++) @(negedge clk);
    check("post-reset responses", SW'(consumed), SW'(total));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
